// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first rep_cnt times, separated by gap_len zero bits.
// Optional frame counter output (frames_sent) enabled by defining SEQ_GEN_FRAME_CNT_EN.
module seq_pattern_gen #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
`ifdef SEQ_GEN_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frames_sent
`endif
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] bit_idx, bit_idx_nx;
  logic [CNT_W-1:0] reps_left, reps_left_nx;
  logic [GAP_W-1:0] gap_len_q, gap_len_nx;
  logic [GAP_W-1:0] gap_left, gap_left_nx;
  logic             dout_nx, dout_vld_nx, busy_nx, done_nx;

  // State tracks what is on dout right now; outputs are registered copies of the next state.
  always_comb begin
    state_nx     = state;
    bit_idx_nx   = bit_idx;
    reps_left_nx = reps_left;
    gap_len_nx   = gap_len_q;
    gap_left_nx  = gap_left;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (rep_cnt != '0) begin
            state_nx     = SEND;
            bit_idx_nx   = LAST_IDX;
            reps_left_nx = rep_cnt;
            gap_len_nx   = gap_len;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (bit_idx == '0) begin
          reps_left_nx = reps_left - 1'b1;
          if (reps_left <= CNT_W'(1)) begin
            state_nx = DONE;
          end else if (gap_len_q != '0) begin
            state_nx    = GAP;
            gap_left_nx = gap_len_q;
          end else begin
            bit_idx_nx = LAST_IDX;
          end
        end else begin
          bit_idx_nx = bit_idx - 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (gap_left <= GAP_W'(1)) begin
          state_nx   = SEND;
          bit_idx_nx = LAST_IDX;
        end else begin
          gap_left_nx = gap_left - 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    dout_vld_nx = (state_nx == SEND) || (state_nx == GAP);
    busy_nx     = dout_vld_nx;
    done_nx     = (state_nx == DONE);
    dout_nx     = (state_nx == SEND) ? PATTERN[bit_idx_nx] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      reps_left <= '0;
      gap_len_q <= '0;
      gap_left  <= '0;
      dout      <= 1'b0;
      dout_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_idx   <= bit_idx_nx;
      reps_left <= reps_left_nx;
      gap_len_q <= gap_len_nx;
      gap_left  <= gap_left_nx;
      dout      <= dout_nx;
      dout_vld  <= dout_vld_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

`ifdef SEQ_GEN_FRAME_CNT_EN
  // Counts only patterns whose final bit went out without abort; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_sent <= '0;
    end else if ((state == SEND) && (bit_idx == '0) && !abort) begin
      frames_sent <= frames_sent + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected serial symbols are queued by the stimulus
// and popped by a negedge monitor whenever the DUT drives dout_vld or done.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rep_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       abort = 1'b0;
  logic       dout, dout_vld, busy, done;
`ifdef SEQ_GEN_FRAME_CNT_EN
  logic [7:0] frames_sent;
`endif

  seq_pattern_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rep_cnt  (rep_cnt),
    .gap_len  (gap_len),
    .abort    (abort),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .done     (done)
`ifdef SEQ_GEN_FRAME_CNT_EN
    ,
    .frames_sent (frames_sent)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic dout;
    logic done;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Queue the serial symbols a burst is expected to produce, optionally followed by done.
  task automatic push_burst(input string bits, input bit with_done);
    exp_t e;
    for (int i = 0; i < bits.len(); i++) begin
      e.dout = (bits[i] == "1");
      e.done = 1'b0;
      q.push_back(e);
    end
    if (with_done) begin
      e.dout = 1'b0;
      e.done = 1'b1;
      q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that sampled start.
  task automatic issue(input int rep, input int gap);
    rep_cnt = 8'(rep);
    gap_len = 4'(gap);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy && !done) break;
    end
    chk({nm, "_finished"}, (i < 200), 1);
    chk({nm, "_drained"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dout_vld || done) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got vld=%0b dout=%0b done=%0b expected no output at %0t",
                 dout_vld, dout, done, $time);
      end else begin
        e = q.pop_front();
        chk("dout", dout, e.dout);
        chk("done", done, e.done);
        chk("dout_vld", dout_vld, !e.done);
        chk("busy", busy, !e.done);
      end
    end else begin
      chk("idle_quiet", {busy, dout}, 0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {dout, dout_vld, busy, done}, 0);
`ifdef SEQ_GEN_FRAME_CNT_EN
    chk("reset_frames", frames_sent, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Single pattern: latency and done timing
    push_burst("11011", 1);
    issue(1, 0);
    chk("t1_first_vld", {dout_vld, dout, busy}, 3'b111);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_last_bit", {dout_vld, dout, done}, 3'b110);
    @(posedge clk); #1;
    chk("t1_done", {done, busy, dout_vld}, 3'b100);
    @(posedge clk); #1;
    chk("t1_done_once", done, 0);
    wait_idle("t1");

    // Two patterns with a 3-bit gap
    push_burst("1101100011011", 1);
    issue(2, 3);
    wait_idle("t2");

    // Three patterns back to back
    push_burst("110111101111011", 1);
    issue(3, 0);
    wait_idle("t3");
`ifdef SEQ_GEN_FRAME_CNT_EN
    chk("frames_after_t3", frames_sent, 6);
`endif

    // rep_cnt=0 gives only a done pulse
    push_burst("", 1);
    issue(0, 2);
    chk("t4_rep0_done", {done, dout_vld, busy}, 3'b100);
    wait_idle("t4a");

    // start pulses during a burst are ignored
    push_burst("1101111011", 1);
    issue(2, 0);
    repeat (3) @(posedge clk);
    #1;
    rep_cnt = 8'd7; gap_len = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t4b");

    // start presented while in DONE is ignored
    push_burst("11011", 1);
    issue(1, 2);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; rep_cnt = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("done_start_ignored", q.size(), 0);

    // abort after the third bit
    push_burst("110", 0);
    issue(2, 0);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_outputs", {dout, dout_vld, busy, done}, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", q.size(), 0);
`ifdef SEQ_GEN_FRAME_CNT_EN
    chk("frames_after_abort", frames_sent, 9);
`endif
    push_burst("11011", 1);
    issue(1, 2);
    wait_idle("after_abort");

    // abort together with start in IDLE: nothing sent
    abort = 1'b1;
    issue(1, 0);
    abort = 1'b0;
    chk("abort_start_idle", {dout_vld, busy, done}, 0);
    repeat (8) @(posedge clk);
    #1;

    // reset mid-burst
    push_burst("11", 0);
    issue(2, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outputs", {dout, dout_vld, busy, done}, 0);
`ifdef SEQ_GEN_FRAME_CNT_EN
    chk("rst_frames", frames_sent, 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    push_burst("11011", 1);
    issue(1, 0);
    wait_idle("after_rst");
`ifdef SEQ_GEN_FRAME_CNT_EN
    chk("frames_final", frames_sent, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
